// File: rtl/core_adc_supervisor.sv
// core_adc_supervisor: round-robin A2D sequencer with per-channel result latches,
// battery-low hysteresis and a power FSM that gates balance control.
// Optional feature macro CORE_ADC_AVG_EN: each stored sample becomes the mean of
// the previous stored value and the new conversion (first sample after OFF raw).
module core_adc_supervisor #(
    parameter int NUM_CH   = 4,
    parameter int ADC_W    = 12,
    parameter int BATT_CH  = 2,
    parameter int BATT_TH  = 'h800,
    parameter int BATT_HYS = 'h040,
    parameter int TMO_CYC  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwr_up,
    input  logic                       trig,
    output logic                       nxt,
    output logic [$clog2(NUM_CH)-1:0]  ch_sel,
    input  logic                       cnv_done,
    input  logic [ADC_W-1:0]           adc_data,
    output logic [NUM_CH*ADC_W-1:0]    ch_data,
    output logic [NUM_CH-1:0]          ch_vld,
    output logic [NUM_CH-1:0]          ch_err,
    output logic                       sweep_done,
    output logic                       batt_low,
    output logic                       en_bal,
    output logic [1:0]                 state
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int CNT_W  = $clog2(TMO_CYC + 1);
    localparam int ADC_W1 = ADC_W + 1;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]   BATT_SEL = CH_W'(BATT_CH);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO_CYC - 1);
    // Thresholds kept one bit wider so TH+HYS cannot wrap
    localparam logic [ADC_W1-1:0] TH_LO    = ADC_W1'(BATT_TH);
    localparam logic [ADC_W1-1:0] TH_HI    = TH_LO + ADC_W1'(BATT_HYS);

    typedef enum logic [1:0] {OFF = 2'd0, ARM = 2'd1, RUN = 2'd2, FLT = 2'd3} pwr_state_t;
    typedef enum logic [1:0] {SEQ_IDLE = 2'd0, SEQ_REQ = 2'd1, SEQ_WAIT = 2'd2} seq_state_t;

    pwr_state_t          pwr_q, pwr_nxt;
    seq_state_t          seq_q, seq_nxt;
    logic [CNT_W-1:0]    wait_cnt;
    logic [ADC_W-1:0]    slot [NUM_CH];
    logic [NUM_CH-1:0]   last_tmo;
    logic                conv_ok, conv_tmo, sweep_end;
    logic [ADC_W-1:0]    new_val;

`ifdef CORE_ADC_AVG_EN
    function automatic logic [ADC_W-1:0] avg_fn(input logic [ADC_W-1:0] old_v,
                                                 input logic [ADC_W-1:0] new_v);
        logic [ADC_W1-1:0] sum;
        sum = {1'b0, old_v} + {1'b0, new_v};
        return sum[ADC_W1-1:1];
    endfunction
`endif

    // Hysteresis: set below TH, clear at or above TH+HYS, otherwise hold
    function automatic logic batt_fn(input logic cur, input logic [ADC_W-1:0] v);
        logic [ADC_W1-1:0] ve;
        ve = {1'b0, v};
        if (ve < TH_LO)
            return 1'b1;
        else if (ve >= TH_HI)
            return 1'b0;
        return cur;
    endfunction

    // Value written into the selected slot on a successful conversion
    always_comb begin
`ifdef CORE_ADC_AVG_EN
        new_val = ch_vld[ch_sel] ? avg_fn(slot[ch_sel], adc_data) : adc_data;
`else
        new_val = adc_data;
`endif
    end

    // Sequencer next state: request, wait for done or timeout, advance channel
    always_comb begin
        seq_nxt  = seq_q;
        nxt      = 1'b0;
        conv_ok  = 1'b0;
        conv_tmo = 1'b0;
        case (seq_q)
            SEQ_IDLE: if (trig && pwr_q != OFF) seq_nxt = SEQ_REQ;
            SEQ_REQ: begin
                nxt     = 1'b1;
                seq_nxt = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (cnv_done)
                    conv_ok = 1'b1;
                else if (wait_cnt == TMO_LAST)
                    conv_tmo = 1'b1;
                if (conv_ok || conv_tmo)
                    seq_nxt = (ch_sel == LAST_CH) ? SEQ_IDLE : SEQ_REQ;
            end
            default: seq_nxt = SEQ_IDLE;
        endcase
        // Power loss aborts immediately; a late cnv_done is dropped
        if (!pwr_up) begin
            seq_nxt  = SEQ_IDLE;
            conv_ok  = 1'b0;
            conv_tmo = 1'b0;
        end
        sweep_end = (conv_ok || conv_tmo) && (ch_sel == LAST_CH);
    end

    // Power FSM next state; loss of pwr_up overrides every state
    always_comb begin
        pwr_nxt = pwr_q;
        case (pwr_q)
            OFF: if (pwr_up) pwr_nxt = ARM;
            ARM: if (sweep_done) pwr_nxt = (ch_err == '0) ? RUN : FLT;
            RUN: if (conv_tmo && last_tmo[ch_sel]) pwr_nxt = FLT;
            default: pwr_nxt = pwr_q;
        endcase
        if (!pwr_up) pwr_nxt = OFF;
    end

    // Control registers: FSM states, channel pointer, timeout counter, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q      <= SEQ_IDLE;
            pwr_q      <= OFF;
            ch_sel     <= '0;
            wait_cnt   <= '0;
            sweep_done <= 1'b0;
            en_bal     <= 1'b0;
            ch_vld     <= '0;
            ch_err     <= '0;
            last_tmo   <= '0;
            batt_low   <= 1'b0;
        end else begin
            seq_q      <= seq_nxt;
            pwr_q      <= pwr_nxt;
            en_bal     <= (pwr_nxt == RUN);
            sweep_done <= sweep_end;
            wait_cnt   <= (seq_q == SEQ_WAIT) ? wait_cnt + CNT_W'(1) : '0;
            if (!pwr_up) begin
                ch_sel   <= '0;
                ch_vld   <= '0;
                ch_err   <= '0;
                last_tmo <= '0;
                batt_low <= 1'b0;
            end else if (conv_ok || conv_tmo) begin
                ch_sel <= (ch_sel == LAST_CH) ? '0 : ch_sel + CH_W'(1);
                if (conv_ok) begin
                    ch_vld[ch_sel]   <= 1'b1;
                    last_tmo[ch_sel] <= 1'b0;
                    if (ch_sel == BATT_SEL)
                        batt_low <= batt_fn(batt_low, new_val);
                end else begin
                    ch_err[ch_sel]   <= 1'b1;
                    last_tmo[ch_sel] <= 1'b1;
                end
            end
        end
    end

    // Result latches: written only on a successful conversion, retained through OFF
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) slot[i] <= '0;
        end else if (conv_ok) begin
            slot[ch_sel] <= new_val;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign ch_data[g*ADC_W +: ADC_W] = slot[g];
    end

    assign state = pwr_q;

endmodule

// File: tb/tb_core_adc_supervisor.sv
// tb_core_adc_supervisor: randomized sweeps against a sweep-level reference model;
// expected sweep results are queued at issue and checked when sweep_done appears.
module tb_core_adc_supervisor;

    localparam int NUM_CH   = 4;
    localparam int ADC_W    = 12;
    localparam int BATT_CH  = 2;
    localparam int BATT_TH  = 'h800;
    localparam int BATT_HYS = 'h040;
    localparam int TMO_CYC  = 64;
    localparam int BUDGET   = NUM_CH * (TMO_CYC + 12) + 40;

    logic                    clk = 1'b0;
    logic                    rst, pwr_up, trig, nxt, cnv_done;
    logic                    sweep_done, batt_low, en_bal;
    logic [1:0]              ch_sel, state;
    logic [ADC_W-1:0]        adc_data;
    logic [NUM_CH*ADC_W-1:0] ch_data;
    logic [NUM_CH-1:0]       ch_vld, ch_err;

    always #5 clk = ~clk;

    core_adc_supervisor #(
        .NUM_CH(NUM_CH), .ADC_W(ADC_W), .BATT_CH(BATT_CH),
        .BATT_TH(BATT_TH), .BATT_HYS(BATT_HYS), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .pwr_up(pwr_up), .trig(trig), .nxt(nxt),
        .ch_sel(ch_sel), .cnv_done(cnv_done), .adc_data(adc_data),
        .ch_data(ch_data), .ch_vld(ch_vld), .ch_err(ch_err),
        .sweep_done(sweep_done), .batt_low(batt_low), .en_bal(en_bal), .state(state)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [NUM_CH*ADC_W-1:0] data;
        logic [NUM_CH-1:0]       vld;
        logic [NUM_CH-1:0]       err;
        logic                    batt;
        logic [1:0]              st;
    } rec_t;

    rec_t sb_q[$];
    int   sweeps_seen = 0;
    int   plan_lat[NUM_CH];
    int   plan_dat[NUM_CH];
    int   nxt_total = 0;
    int   sweep_base = 0;
    int   spur_req = 0;
    bit   abort_run = 0;

    // Reference model state (spec-level view of the block)
    int          exp_data[NUM_CH];
    logic [NUM_CH-1:0] exp_vld, exp_err, prev_tmo;
    logic        exp_batt;
    int          pstate;   // 0 OFF, 1 ARM, 2 RUN, 3 FLT

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*ADC_W-1:0] pack_exp();
        logic [NUM_CH*ADC_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*ADC_W +: ADC_W] = ADC_W'(exp_data[c]);
        return v;
    endfunction

    // One channel's conversion outcome, from the plan, applied to the model
    task automatic model_chan(input int c);
        int lat, v;
        lat = plan_lat[c];
        if (lat >= 1 && lat <= TMO_CYC) begin
            v = plan_dat[c] & 'hFFF;
`ifdef CORE_ADC_AVG_EN
            if (exp_vld[c]) v = (exp_data[c] + v) / 2;
`endif
            exp_data[c] = v;
            exp_vld[c]  = 1'b1;
            if (c == BATT_CH) begin
                if (v < BATT_TH) exp_batt = 1'b1;
                else if (v >= BATT_TH + BATT_HYS) exp_batt = 1'b0;
            end
            prev_tmo[c] = 1'b0;
        end else begin
            exp_err[c] = 1'b1;
            if (pstate == 2 && prev_tmo[c]) pstate = 3;
            prev_tmo[c] = 1'b1;
        end
    endtask

    task automatic model_off();
        exp_vld  = '0;
        exp_err  = '0;
        prev_tmo = '0;
        exp_batt = 1'b0;
        pstate   = 0;
    endtask

    // A2D responder: answers each nxt according to the plan, plus spurious strobes on request
    initial begin
        int cd_cnt, cd_dat, idx, spur_done;
        cd_cnt = 0; cd_dat = 0; spur_done = 0;
        cnv_done = 1'b0; adc_data = '0;
        forever begin
            @(negedge clk);
            cnv_done = 1'b0;
            if (cd_cnt > 0) begin
                cd_cnt--;
                if (cd_cnt == 0) begin
                    cnv_done = 1'b1;
                    adc_data = ADC_W'(cd_dat);
                end
            end else if (spur_done < spur_req) begin
                spur_done++;
                cnv_done = 1'b1;
                adc_data = ADC_W'($urandom);
            end
            if (nxt === 1'b1) begin
                idx = nxt_total - sweep_base;
                nxt_total++;
                chk("nxt_in_sweep", 64'(idx < NUM_CH), 1);
                if (idx < NUM_CH) begin
                    chk("nxt_ch_sel", 64'(ch_sel), 64'(idx));
                    cd_cnt = plan_lat[idx];
                    cd_dat = plan_dat[idx];
                end
            end
        end
    end

    // Monitor: pops the expected sweep whenever the DUT pulses sweep_done
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (sweep_done === 1'b1) begin
                chk("sd_pending", 64'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    r = sb_q.pop_front();
                    chk("sd_ch_data", 64'(ch_data), 64'(r.data));
                    chk("sd_ch_vld", 64'(ch_vld), 64'(r.vld));
                    chk("sd_ch_err", 64'(ch_err), 64'(r.err));
                    chk("sd_batt_low", 64'(batt_low), 64'(r.batt));
                    @(negedge clk);
                    chk("sd_state", 64'(state), 64'(r.st));
                    chk("sd_en_bal", 64'(en_bal), 64'(r.st == 2'd2));
                    chk("sd_pulse_1cyc", 64'(sweep_done), 0);
                end
                sweeps_seen++;
            end
        end
    end

    task automatic do_sweep(input bit extra_trig, input bit spur);
        rec_t r;
        int target;
        if (abort_run) return;
        if (spur) begin
            spur_req++;
            repeat (3) @(negedge clk);
        end
        for (int c = 0; c < NUM_CH; c++) model_chan(c);
        if (pstate == 1) pstate = (exp_err == '0) ? 2 : 3;
        r.data = pack_exp(); r.vld = exp_vld; r.err = exp_err;
        r.batt = exp_batt;   r.st = 2'(pstate);
        sb_q.push_back(r);
        sweep_base = nxt_total;
        target = sweeps_seen + 1;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        for (int i = 0; i < BUDGET && sweeps_seen < target; i++) begin
            @(negedge clk);
            trig = (extra_trig && i == 2);
        end
        trig = 1'b0;
        chk("sweep_wait", 64'(sweeps_seen), 64'(target));
        if (sweeps_seen < target) abort_run = 1;
        chk("nxt_count", 64'(nxt_total - sweep_base), NUM_CH);
        chk("ch_sel_home", 64'(ch_sel), 0);
    endtask

    task automatic power_cycle();
        if (abort_run) return;
        pwr_up = 1'b0;
        repeat (2) @(negedge clk);
        model_off();
        chk("off_state", 64'(state), 0);
        chk("off_en_bal", 64'(en_bal), 0);
        chk("off_ch_vld", 64'(ch_vld), 0);
        chk("off_ch_err", 64'(ch_err), 0);
        chk("off_batt_low", 64'(batt_low), 0);
        chk("off_ch_data_kept", 64'(ch_data), 64'(pack_exp()));
        pwr_up = 1'b1;
        @(negedge clk);
        pstate = 1;
        chk("arm_state", 64'(state), 1);
    endtask

    task automatic plan_ok(input int lat);
        for (int c = 0; c < NUM_CH; c++) begin
            plan_lat[c] = lat;
            plan_dat[c] = int'($urandom_range(0, 'hFFF));
        end
    endtask

    task automatic plan_random();
        int r;
        for (int c = 0; c < NUM_CH; c++) begin
            r = int'($urandom_range(0, 11));
            plan_lat[c] = (r == 0) ? 0 : (r == 1) ? TMO_CYC + 1 : int'($urandom_range(1, 8));
            plan_dat[c] = (c == BATT_CH) ? BATT_TH - 'h60 + int'($urandom_range(0, 'hC0))
                                         : int'($urandom_range(0, 'hFFF));
        end
    endtask

    task automatic random_sweeps(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 4) == 0) power_cycle();
            plan_random();
            do_sweep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    // pwr_up drops during WAIT on ch2; the A2D answers two cycles after the drop
    task automatic abort_test();
        bit found;
        int old2;
        if (abort_run) return;
        plan_ok(2);
        plan_lat[2] = 3;
        plan_dat[2] = 'hABC;
        model_chan(0);
        model_chan(1);
        old2 = exp_data[2];
        sweep_base = nxt_total;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        found = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge clk);
            if (nxt === 1'b1 && ch_sel == 2'd2) found = 1;
        end
        chk("abort_reach_ch2", 64'(found), 1);
        @(negedge clk);
        pwr_up = 1'b0;
        repeat (4) @(negedge clk);
        model_off();
        chk("abort_state", 64'(state), 0);
        chk("abort_ch_vld", 64'(ch_vld), 0);
        chk("abort_ch2_kept", 64'(ch_data[2*ADC_W +: ADC_W]), 64'(old2));
        chk("abort_ch_data", 64'(ch_data), 64'(pack_exp()));
        chk("abort_nxt_count", 64'(nxt_total - sweep_base), 3);
        chk("abort_ch_sel", 64'(ch_sel), 0);
        pwr_up = 1'b1;
        @(negedge clk);
        pstate = 1;
        chk("abort_rearm", 64'(state), 1);
    endtask

    // Stimulus sequence
    initial begin
        for (int c = 0; c < NUM_CH; c++) exp_data[c] = 0;
        model_off();
        rst = 1'b1; pwr_up = 1'b1; trig = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_state", 64'(state), 0);
        chk("rst_nxt", 64'(nxt), 0);
        chk("rst_ch_sel", 64'(ch_sel), 0);
        chk("rst_ch_data", 64'(ch_data), 0);
        chk("rst_ch_vld", 64'(ch_vld), 0);
        chk("rst_ch_err", 64'(ch_err), 0);
        chk("rst_sweep_done", 64'(sweep_done), 0);
        chk("rst_batt_low", 64'(batt_low), 0);
        chk("rst_en_bal", 64'(en_bal), 0);
        rst = 1'b0;
        @(negedge clk);
        pstate = 1;
        chk("rst_release_arm", 64'(state), 1);

        // Directed first sweep 0x111..0x444, 5-cycle latency
        for (int c = 0; c < NUM_CH; c++) begin
            plan_lat[c] = 5;
            plan_dat[c] = (c + 1) * 'h111;
        end
        do_sweep(0, 0);
        chk("t2_ch_data", 64'(ch_data), 64'h444333222111);
        chk("t2_ch_vld", 64'(ch_vld), 4'hF);
        chk("t2_state", 64'(state), 2);
        chk("t2_en_bal", 64'(en_bal), 1);

        // Battery hysteresis sequence
        plan_ok(3); plan_dat[BATT_CH] = 'h7FF; do_sweep(0, 0);
        plan_ok(3); plan_dat[BATT_CH] = 'h820; do_sweep(0, 0);
        plan_ok(3); plan_dat[BATT_CH] = 'h840; do_sweep(0, 0);

        random_sweeps(8);

        // Two consecutive timeouts on the same channel in RUN
        power_cycle();
        plan_ok(2); do_sweep(0, 0);
        plan_ok(2); plan_lat[3] = 0; do_sweep(0, 0);
        plan_ok(2); plan_lat[0] = 0; do_sweep(0, 0);
        if (!abort_run) chk("dbl_tmo_diff_ch_run", 64'(state), 2);
        plan_ok(2); plan_lat[0] = 0; do_sweep(0, 0);
        if (!abort_run) chk("dbl_tmo_same_ch_flt", 64'(state), 3);

        // Done on the timeout cycle counts; one cycle later is a timeout
        power_cycle();
        plan_ok(2); do_sweep(0, 0);
        plan_ok(2); plan_lat[1] = TMO_CYC; plan_lat[3] = TMO_CYC + 1; do_sweep(0, 0);

        // Channel 1 never answers during ARM
        power_cycle();
        plan_ok(2); plan_lat[1] = 0; do_sweep(0, 0);
        if (!abort_run) begin
            chk("t4_state", 64'(state), 3);
            chk("t4_en_bal", 64'(en_bal), 0);
            chk("t4_ch_err", 64'(ch_err), 4'b0010);
        end

        power_cycle();
        abort_test();

        // Channel 0 samples 0x100 then 0x201 after a power cycle
        power_cycle();
        plan_ok(2); plan_dat[0] = 'h100; do_sweep(0, 0);
        plan_ok(2); plan_dat[0] = 'h201; do_sweep(0, 0);

        random_sweeps(6);

        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
